uart_rx_frame: RTL
==================

# uart_rx_frame

Parametrised UART receive engine; successor to the fixed 8N1 receiver. Takes an already-synchronised serial line plus an oversampling tick from the baud generator, performs start/data/parity/stop framing with mid-bit sampling, and presents each received word through a valid/ready holding register with per-word error flags, overrun and break detection. Sits between the baud/synchroniser front end and the command decoder.

## Interface

Parameters:
- DATA_BITS, 8, data bits per frame, legal 5..9
- OVERSAMPLE, 16, sample_tick pulses per bit period, even, legal 4..64
- STOP_BITS, 1, stop bits checked, legal 1 or 2
- PARITY_ODD, 0, 0 = even parity, 1 = odd parity (only with UART_RX_PARITY_EN)

Ports:
- clk  input  1  system clock; all logic on rising edge
- reset_n  input  1  asynchronous, active-low reset
- rx_sync_in  input  1  serial line, already synchronised to clk, idle high
- sample_tick  input  1  one-cycle strobe at OVERSAMPLE × baud
- rx_data  output  DATA_BITS  received word, LSB = first bit on line
- rx_valid  output  1  holding register full
- rx_ready  input  1  consumer accepts word when rx_valid && rx_ready
- frame_error  output  1  stop bit sampled low for the held word
- parity_error  output  1  parity mismatch for the held word
- overrun  output  1  one-cycle pulse: completed frame dropped
- break_det  output  1  one-cycle pulse: break condition detected
- busy  output  1  high whenever state ≠ IDLE

## Operation

- States: IDLE, START, DATA, PARITY, STOP, BREAK_WAIT. Tick counter cnt (width clog2(OVERSAMPLE)), bit counter, shift register.
- All state/counter changes occur only on cycles with sample_tick = 1, except handshake logic (every clk).
- IDLE: on tick with rx_sync_in = 0 → START, cnt = 0.
- START: count ticks; on tick where cnt reaches OVERSAMPLE/2−1 sample line. High → false start, back to IDLE, nothing reported. Low → DATA, cnt = 0, bit counter = 0.
- DATA/PARITY/STOP: each bit sampled on the tick where cnt reaches OVERSAMPLE−1 (mid-bit), then cnt = 0. DATA shifts LSB-first for DATA_BITS samples; then PARITY (if compiled in) else STOP; STOP samples STOP_BITS bits, any low sample sets frame error.
- Parity: XOR of data bits plus parity bit must equal PARITY_ODD; otherwise parity error.
- Break: all data bits 0, parity bit 0 (if present) and first stop sample 0 → break_det pulse, word still delivered with frame_error = 1, state → BREAK_WAIT; stays there until a tick sees rx_sync_in = 1, then IDLE. Otherwise after last stop sample → IDLE.
- Delivery at end of stop: if rx_valid = 0, or rx_valid && rx_ready this cycle, load rx_data, frame_error, parity_error, set rx_valid. Else keep old word, pulse overrun.
- rx_valid clears on the cycle after rx_valid && rx_ready (unless simultaneous load). Flags change only with a load.

## Timing

- Reset: state IDLE, all counters 0; rx_data = 0, rx_valid = 0, all flags/pulses = 0, busy = 0. Reset mid-frame aborts with nothing reported.
- rx_valid, error flags and break_det/overrun assert the clk cycle after the tick sampling the last stop bit (one-cycle latency).
- Start sampled OVERSAMPLE/2 ticks after falling-edge detection; each following bit exactly OVERSAMPLE ticks later.
- Back-to-back frames: a new start may be detected on the tick after the last stop sample (no gap required).
- rx_ready ignored while rx_valid = 0.

## Configuration

- UART_RX_PARITY_EN defined: PARITY state present, one parity bit expected after data, parity_error driven per PARITY_ODD.
- Not defined: no parity bit in frame (DATA → STOP directly), PARITY_ODD ignored, parity_error tied 0.

## Test plan

- 8N1, OVERSAMPLE=16, send 0xA5, rx_ready = 1 → rx_data = 0xA5, rx_valid one cycle, no flags.
- Parity enabled even, send 0x07 with parity bit 0 → rx_data = 0x07, parity_error = 1; with parity 1 → parity_error = 0.
- Low glitch of 4 ticks on idle line → no rx_valid, busy returns 0, state IDLE.
- Send 0x11 then 0x22 with rx_ready = 0 → rx_data stays 0x11, overrun pulses once at end of 0x22; rx_ready = 1 on that same cycle instead → 0x22 loaded, no overrun.
- Hold line low for 20 bit periods → break_det pulse, rx_data = 0x00, frame_error = 1, busy until line returns high, then one clean 0x5A frame received correctly.
- DATA_BITS=9, STOP_BITS=2, send 0x1F3 with second stop bit low → rx_data = 0x1F3, frame_error = 1; assert reset_n = 0 mid-frame → all outputs 0 next cycle.

Source files
------------

// File: rtl/uart_rx_frame.sv
// uart_rx_frame: UART receiver with start/data/[parity]/stop framing and mid-bit sampling; optional parity via UART_RX_PARITY_EN.
// Latency: word, flags and break/overrun pulses appear one clk after the tick that samples the last stop bit.
// Backpressure: single valid/ready holding register; a frame completing while it is still full is dropped and overrun pulses.
module uart_rx_frame #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int STOP_BITS  = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 rx_sync_in,
    input  logic                 sample_tick,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_error,
    output logic                 parity_error,
    output logic                 overrun,
    output logic                 break_det,
    output logic                 busy
);
    localparam int CW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS);
    localparam logic [CW-1:0] HALF_PT   = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] FULL_PT   = CW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] LAST_DATA = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);
    localparam logic          ODD       = 1'(PARITY_ODD);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK_WAIT} state_t;

    state_t               state, state_nxt;
    logic [CW-1:0]        cnt;
    logic [BW-1:0]        bit_cnt;
    logic [DATA_BITS-1:0] shift;
    logic                 stop_low;   // an earlier stop sample of this frame was low
    logic                 stop0_low;  // the first stop sample of this frame was low
    logic                 cnt_clr;
    logic                 bit_pt;
    logic                 frame_end;
    logic                 first_stop_low;
    logic                 fe_calc;
    logic                 pe_calc;
    logic                 brk_calc;

`ifdef UART_RX_PARITY_EN
    logic par_bit;
    assign pe_calc  = ((^shift) ^ par_bit) != ODD;
    assign brk_calc = (shift == '0) && !par_bit && first_stop_low;
`else
    // No parity bit on the line, so the flag can never rise and the polarity is irrelevant.
    assign pe_calc  = ODD & 1'b0;
    assign brk_calc = (shift == '0) && first_stop_low;
`endif

    // With one stop bit the current sample is the first; with two it was captured earlier.
    assign first_stop_low = (bit_cnt == '0) ? !rx_sync_in : stop0_low;
    assign fe_calc        = stop_low | !rx_sync_in;
    assign busy           = (state != IDLE);

    // Next-state and sample-point decode; nothing moves without a sample tick.
    always_comb begin
        state_nxt = state;
        cnt_clr   = 1'b0;
        bit_pt    = 1'b0;
        frame_end = 1'b0;
        if (sample_tick) begin
            case (state)
                IDLE: begin
                    cnt_clr = 1'b1;
                    if (!rx_sync_in) state_nxt = START;
                end
                START: begin
                    if (cnt == HALF_PT) begin
                        cnt_clr = 1'b1;
                        if (rx_sync_in) state_nxt = IDLE;
                        else            state_nxt = DATA;
                    end
                end
                DATA: begin
                    if (cnt == FULL_PT) begin
                        cnt_clr = 1'b1;
                        bit_pt  = 1'b1;
                        if (bit_cnt == LAST_DATA) begin
`ifdef UART_RX_PARITY_EN
                            state_nxt = PARITY;
`else
                            state_nxt = STOP;
`endif
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (cnt == FULL_PT) begin
                        cnt_clr   = 1'b1;
                        bit_pt    = 1'b1;
                        state_nxt = STOP;
                    end
                end
`endif
                STOP: begin
                    if (cnt == FULL_PT) begin
                        cnt_clr = 1'b1;
                        bit_pt  = 1'b1;
                        if (bit_cnt == LAST_STOP) begin
                            frame_end = 1'b1;
                            if (brk_calc) state_nxt = BREAK_WAIT;
                            else          state_nxt = IDLE;
                        end
                    end
                end
                BREAK_WAIT: begin
                    cnt_clr = 1'b1;
                    if (rx_sync_in) state_nxt = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Framing state, tick/bit counters and the bit capture registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            cnt       <= '0;
            bit_cnt   <= '0;
            shift     <= '0;
            stop_low  <= 1'b0;
            stop0_low <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bit   <= 1'b0;
`endif
        end else if (sample_tick) begin
            state <= state_nxt;
            cnt   <= cnt_clr ? '0 : cnt + CW'(1);
            if (state_nxt != state) bit_cnt <= '0;
            else if (bit_pt)        bit_cnt <= bit_cnt + BW'(1);
            if (state == IDLE) stop_low <= 1'b0;
            if (bit_pt) begin
                case (state)
                    DATA: shift <= {rx_sync_in, shift[DATA_BITS-1:1]};
`ifdef UART_RX_PARITY_EN
                    PARITY: par_bit <= rx_sync_in;
`endif
                    STOP: begin
                        stop_low <= stop_low | !rx_sync_in;
                        if (bit_cnt == '0) stop0_low <= !rx_sync_in;
                    end
                    default: ;
                endcase
            end
        end
    end

    // Holding register: load on frame end when free or being drained, else drop and flag overrun.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_data      <= '0;
            rx_valid     <= 1'b0;
            frame_error  <= 1'b0;
            parity_error <= 1'b0;
            overrun      <= 1'b0;
            break_det    <= 1'b0;
        end else begin
            overrun   <= 1'b0;
            break_det <= frame_end & brk_calc;
            if (frame_end && (!rx_valid || rx_ready)) begin
                rx_data      <= shift;
                frame_error  <= fe_calc;
                parity_error <= pe_calc;
                rx_valid     <= 1'b1;
            end else begin
                if (frame_end)            overrun  <= 1'b1;
                if (rx_valid && rx_ready) rx_valid <= 1'b0;
            end
        end
    end
endmodule
